// File: rtl/tcpc_regbank_gen.sv
// tcpc_regbank_gen: TCPC host register bank with RO, W1C alert and RW regions.
// Optional write lock on byte DEPTH-1 when REGBANK_WR_LOCK_EN is defined.
module tcpc_regbank_gen #(
   parameter int unsigned LANES       = 2,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned RO_BYTES    = 16,
   parameter logic [7:0]  ALERT_ADDR  = 8'h10,
   parameter logic [7:0]  MASK_ADDR   = 8'h12,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    REQUEST,
   input  logic                    RNW,
   input  logic                    SIZE,
   input  logic [7:0]              ADDR,
   input  logic [8*LANES-1:0]      WR_DATA,
   output logic [8*LANES-1:0]      RD_DATA,
   output logic                    ACK,
   output logic                    ERR,
   input  logic [8*RO_BYTES-1:0]   RO_BUS,
   input  logic [8*LANES-1:0]      ALERT_SET,
   output logic                    IRQ
);
   localparam int unsigned DATA_W = 8 * LANES;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [8:0] DEPTH9 = 9'(DEPTH);
   localparam logic [8:0] RO9 = 9'(RO_BYTES);
   localparam logic [3:0] WS_LAST =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
`ifdef REGBANK_WR_LOCK_EN
   localparam logic [8:0] LOCK9 = 9'(DEPTH - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_HOLD
   } state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              q_rnw;
   logic              q_size;
   logic [7:0]        q_addr;
   logic [DATA_W-1:0] q_wdata;
   logic [7:0]        mem [DEPTH];
   logic [DATA_W-1:0] alert;
   logic [DATA_W-1:0] mask;
`ifdef REGBANK_WR_LOCK_EN
   logic              lock;
   logic              lock_we;
   logic              lock_nxt;
   logic [LANES-1:0]  hit_lock;
`endif

   logic              cur_rnw;
   logic              cur_size;
   logic [7:0]        cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic              do_acc;
   logic              acc_err;
   logic              wr_ok;
   logic [8:0]        lane_addr [LANES];
   logic [LANES-1:0]  lane_on;
   logic [LANES-1:0]  hit_alert;
   logic [LANES-1:0]  hit_mask;
   logic [LANES-1:0]  mem_we;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] alert_clr;
   logic [DATA_W-1:0] mask_nxt;
   logic [7:0]        bval;

   // The access executes on the edge that enters RESP, so ACK shows in RESP.
   always_comb begin
      cur_rnw   = (state == S_IDLE) ? RNW     : q_rnw;
      cur_size  = (state == S_IDLE) ? SIZE    : q_size;
      cur_addr  = (state == S_IDLE) ? ADDR    : q_addr;
      cur_wdata = (state == S_IDLE) ? WR_DATA : q_wdata;
      do_acc = 1'b0;
      if (state == S_IDLE)
         do_acc = REQUEST && (WAIT_STATES == 0);
      else if (state == S_WAIT)
         do_acc = (cnt == WS_LAST);
      acc_err   = 1'b0;
      rdata     = '0;
      bval      = 8'h00;
      lane_on   = '0;
      hit_alert = '0;
      hit_mask  = '0;
`ifdef REGBANK_WR_LOCK_EN
      hit_lock  = '0;
`endif
      for (int k = 0; k < LANES; k++) begin
         lane_addr[k] = {1'b0, cur_addr} + 9'(k);
         lane_on[k] = (k == 0) || cur_size;
         for (int j = 0; j < LANES; j++) begin
            if (lane_addr[k] == {1'b0, ALERT_ADDR} + 9'(j))
               hit_alert[k] = 1'b1;
            if (lane_addr[k] == {1'b0, MASK_ADDR} + 9'(j))
               hit_mask[k] = 1'b1;
         end
`ifdef REGBANK_WR_LOCK_EN
         hit_lock[k] = (lane_addr[k] == LOCK9);
`endif
         if (lane_on[k]) begin
            if (lane_addr[k] >= DEPTH9)
               acc_err = 1'b1;
            else if (!cur_rnw && lane_addr[k] < RO9)
               acc_err = 1'b1;
`ifdef REGBANK_WR_LOCK_EN
            else if (!cur_rnw && lock && !hit_alert[k] && !hit_lock[k])
               acc_err = 1'b1;
`endif
            bval = mem[lane_addr[k][AW-1:0]];
            for (int j = 0; j < LANES; j++) begin
               if (lane_addr[k] == {1'b0, ALERT_ADDR} + 9'(j))
                  bval = alert[8*j +: 8];
               if (lane_addr[k] == {1'b0, MASK_ADDR} + 9'(j))
                  bval = mask[8*j +: 8];
            end
            for (int i = 0; i < RO_BYTES; i++)
               if (lane_addr[k] == 9'(i))
                  bval = RO_BUS[8*i +: 8];
`ifdef REGBANK_WR_LOCK_EN
            if (hit_lock[k])
               bval = {7'b0, lock};
`endif
            rdata[8*k +: 8] = bval;
         end
      end
      if (acc_err)
         rdata = '0;

      wr_ok     = do_acc && !acc_err && !cur_rnw;
      alert_clr = '0;
      mask_nxt  = mask;
      mem_we    = '0;
`ifdef REGBANK_WR_LOCK_EN
      lock_we   = 1'b0;
      lock_nxt  = lock;
`endif
      for (int k = 0; k < LANES; k++) begin
         if (wr_ok && lane_on[k]) begin
            for (int j = 0; j < LANES; j++) begin
               if (lane_addr[k] == {1'b0, ALERT_ADDR} + 9'(j))
                  alert_clr[8*j +: 8] = cur_wdata[8*k +: 8];
               if (lane_addr[k] == {1'b0, MASK_ADDR} + 9'(j))
                  mask_nxt[8*j +: 8] = cur_wdata[8*k +: 8];
            end
`ifdef REGBANK_WR_LOCK_EN
            if (hit_lock[k]) begin
               lock_we  = 1'b1;
               lock_nxt = cur_wdata[8*k];
            end else if (!hit_alert[k] && !hit_mask[k])
               mem_we[k] = 1'b1;
`else
            if (!hit_alert[k] && !hit_mask[k])
               mem_we[k] = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         q_rnw   <= 1'b0;
         q_size  <= 1'b0;
         q_addr  <= '0;
         q_wdata <= '0;
         ACK     <= 1'b0;
         ERR     <= 1'b0;
         RD_DATA <= '0;
         IRQ     <= 1'b0;
         alert   <= '0;
         mask    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 8'h00;
`ifdef REGBANK_WR_LOCK_EN
         lock    <= 1'b0;
`endif
      end else begin
         // Hardware set wins over a same-cycle W1C clear.
         alert <= (alert & ~alert_clr) | ALERT_SET;
         mask  <= mask_nxt;
         IRQ   <= |(alert & mask);
         ACK   <= 1'b0;
         ERR   <= 1'b0;
         if (do_acc) begin
            ACK     <= 1'b1;
            ERR     <= acc_err;
            RD_DATA <= rdata;
         end
         for (int k = 0; k < LANES; k++)
            if (mem_we[k])
               mem[lane_addr[k][AW-1:0]] <= cur_wdata[8*k +: 8];
`ifdef REGBANK_WR_LOCK_EN
         if (lock_we)
            lock <= lock_nxt;
`endif
         unique case (state)
            S_IDLE: begin
               if (REQUEST) begin
                  q_rnw   <= RNW;
                  q_size  <= SIZE;
                  q_addr  <= ADDR;
                  q_wdata <= WR_DATA;
                  cnt     <= '0;
                  state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == WS_LAST)
                  state <= S_RESP;
               else
                  cnt <= cnt + 4'd1;
            end
            S_RESP: state <= S_HOLD;
            S_HOLD: if (!REQUEST) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
